// File: rtl/sramlike_axi_arbiter_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: FSM states, size codes,
// default AXI IDs and the latched transaction record.
package sramlike_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
    localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

    typedef struct packed {
        logic        owner_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

endpackage

// File: rtl/sramlike_wstrb_gen.sv
// Byte-lane write strobe from access size and the low address bits.
module sramlike_wstrb_gen
    import sramlike_axi_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sramlike_axi_arbiter.sv
// Two SRAM-like masters (inst read-only, data read/write) bridged onto one AXI
// port with a single outstanding transaction; the data side has priority.
module sramlike_axi_arbiter
    import sramlike_axi_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
    parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic        bvalid,
    output logic        bready
);

    state_t state, state_nxt;
    txn_t   txn;
    logic   aw_done, w_done;
    logic   aw_hs, w_hs, grant;
    logic   unused_ids;

    // Single outstanding transaction: response IDs carry no routing information.
    assign unused_ids = ^{rid, bid};

    assign data_addr_ok = (state == ST_IDLE) & data_req;
    assign inst_addr_ok = (state == ST_IDLE) & inst_req & ~data_req;
    assign grant        = data_addr_ok | inst_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == ST_WR_ADDR) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end
        end
    end

    // Payload holds from grant until the next grant, so AXI fields stay stable
    // whatever the requesters do meanwhile.
    always_ff @(posedge clk) begin
        if (grant) begin
            txn.owner_data <= data_req;
            txn.wr         <= data_req & data_wr;
            txn.size       <= data_req ? data_size : SIZE_WORD;
            txn.addr       <= data_req ? data_addr : inst_addr;
            txn.wdata      <= data_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (data_req)      state_nxt = data_wr ? ST_WR_ADDR : ST_RD_ADDR;
                else if (inst_req) state_nxt = ST_RD_ADDR;
            end
            ST_RD_ADDR: if (arready)          state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (rvalid && rlast)  state_nxt = ST_IDLE;
            ST_WR_ADDR: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (bvalid)           state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    assign arvalid = (state == ST_RD_ADDR);
    assign arid    = txn.owner_data ? DATA_ID : INST_ID;
    assign araddr  = txn.addr;
    assign arsize  = {1'b0, txn.size};
    assign arlen   = 8'd0;
    assign rready  = (state == ST_RD_DATA);

    assign awvalid = (state == ST_WR_ADDR) & ~aw_done;
    assign wvalid  = (state == ST_WR_ADDR) & ~w_done;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign awid    = DATA_ID;
    assign awaddr  = txn.addr;
    assign awsize  = {1'b0, txn.size};
    assign awlen   = 8'd0;
    assign wdata   = txn.wdata;
    assign wlast   = 1'b1;
    assign bready  = (state == ST_WR_RESP);

    sramlike_wstrb_gen u_wstrb (
        .size    (txn.size),
        .addr_lo (txn.addr[1:0]),
        .wstrb   (wstrb)
    );

    assign inst_data_ok = rready & rvalid & rlast & ~txn.owner_data;
    assign data_data_ok = (rready & rvalid & rlast & txn.owner_data) | (bready & bvalid);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

endmodule

// File: tb/tb_sramlike_axi_arbiter.sv
// Directed and randomized checks of the SRAM-like to AXI bridge against a
// transaction-level expectation model and a scripted AXI slave.
module tb_sramlike_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, awid, rid, bid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sramlike_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {arvalid, awvalid, wvalid, rready, bready, inst_data_ok, data_data_ok}, 7'd0);
    endtask

    task automatic slave_quiet();
        arready = 0; rvalid = 0; rlast = 0; rdata = $urandom; rid = $urandom;
        awready = 0; wready = 0; bvalid = 0; bid = $urandom;
    endtask

    // Requesters wander after a grant; nothing they do may leak onto the bus.
    task automatic scramble();
        inst_req = 1'($urandom); data_req = 1'($urandom);
        inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom); data_size = 2'($urandom);
    endtask

    // Expected strobe from byte count and offset: n bytes starting at addr[1:0].
    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << sz;
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    // One complete transaction with fixed slave wait counts (a: AR/AW wait,
    // b: R/W wait, c: B wait). Data side wins whenever it requests.
    task automatic run_txn(input bit ir, input bit dr, input bit wr, input logic [1:0] sz,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                           input logic [31:0] rv, input int a, input int b, input int c);
        logic [31:0] ea;
        logic [2:0]  es;
        logic [3:0]  eid;
        int          n;
        ea  = dr ? da : ia;
        es  = dr ? {1'b0, sz} : 3'd2;
        eid = dr ? 4'd1 : 4'd0;
        @(negedge clk);
        slave_quiet();
        inst_req = ir; inst_addr = ia; data_req = dr; data_wr = wr;
        data_size = sz; data_addr = da; data_wdata = wd;
        #1;
        chk("grant_data", data_addr_ok, dr);
        chk("grant_inst", inst_addr_ok, ir & ~dr);
        if (!(dr && wr)) begin
            for (int k = 0; k <= a; k++) begin
                @(negedge clk); slave_quiet(); scramble(); arready = (k == a); #1;
                chk("arvalid", arvalid, 1);
                chk("araddr", araddr, ea);
                chk("arsize", arsize, es);
                chk("arid", arid, eid);
                chk("arlen", arlen, 0);
                chk("no_ack_busy", {inst_addr_ok, data_addr_ok}, 0);
            end
            for (int k = 0; k <= b; k++) begin
                @(negedge clk); slave_quiet(); scramble();
                rvalid = (k == b); rlast = (k == b); if (k == b) rdata = rv; #1;
                chk("rready", rready, 1);
                chk("inst_data_ok", inst_data_ok, (k == b) && !dr);
                chk("data_data_ok", data_data_ok, (k == b) && dr);
                if (k == b) chk("rdata", dr ? data_rdata : inst_rdata, rv);
            end
        end else begin
            n = (a > b) ? a : b;
            for (int k = 0; k <= n; k++) begin
                @(negedge clk); slave_quiet(); scramble();
                awready = (k == a) ? 1'b1 : (k > a) ? 1'($urandom) : 1'b0;
                wready  = (k == b) ? 1'b1 : (k > b) ? 1'($urandom) : 1'b0;
                #1;
                chk("awvalid", awvalid, k <= a);
                chk("wvalid", wvalid, k <= b);
                chk("bready_early", bready, 0);
                if (k <= a) begin
                    chk("awaddr", awaddr, ea);
                    chk("awsize", awsize, es);
                    chk("aw_id_len", {awid, awlen}, {4'd1, 8'd0});
                end
                if (k <= b) begin
                    chk("wdata", wdata, wd);
                    chk("wstrb", wstrb, model_strb(sz, da));
                    chk("wlast", wlast, 1);
                end
            end
            for (int k = 0; k <= c; k++) begin
                @(negedge clk); slave_quiet(); scramble(); bvalid = (k == c); #1;
                chk("bready", bready, 1);
                chk("wr_data_ok", {data_data_ok, inst_data_ok}, {(k == c), 1'b0});
            end
        end
        @(negedge clk); slave_quiet(); inst_req = 0; data_req = 0; #1;
        chk_idle("idle_after");
    endtask

    initial begin
        reset = 1; inst_req = 0; data_req = 0; data_wr = 0; data_size = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0;
        slave_quiet();
        @(negedge clk); #1;
        chk_idle("reset_state");
        chk("reset_ack", {inst_addr_ok, data_addr_ok}, 0);
        @(negedge clk); reset = 0;

        // zero-wait instruction fetch: ack, AR, R on consecutive cycles
        run_txn(1, 0, 0, 2'd2, 32'hBFC0_0000, 0, 0, 32'h3C1D_BFC0, 0, 0, 0);

        // simultaneous requests: data first, inst held until the next idle cycle
        @(negedge clk); slave_quiet();
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_1000; #1;
        chk("both_data_ok", data_addr_ok, 1);
        chk("both_inst_ok", inst_addr_ok, 0);
        @(negedge clk); data_req = 0; arready = 1; #1;
        chk("both_arid", arid, 1);
        chk("both_araddr", araddr, 32'h8000_1000);
        chk("both_inst_wait1", inst_addr_ok, 0);
        @(negedge clk); arready = 0; rvalid = 1; rlast = 1; rdata = 32'hDEAD_BEEF; #1;
        chk("both_ddata_ok", data_data_ok, 1);
        chk("both_drdata", data_rdata, 32'hDEAD_BEEF);
        chk("both_inst_wait2", {inst_addr_ok, inst_data_ok}, 0);
        @(negedge clk); slave_quiet(); #1;
        chk("both_inst_grant", inst_addr_ok, 1);
        @(negedge clk); inst_req = 0; arready = 1; #1;
        chk("both_inst_ar", {arid, araddr}, {4'd0, 32'hBFC0_0100});
        @(negedge clk); slave_quiet(); rvalid = 1; rlast = 1; rdata = 32'h1234_5678; #1;
        chk("both_inst_done", {inst_data_ok, inst_rdata}, {1'b1, 32'h1234_5678});
        @(negedge clk); slave_quiet(); #1;
        chk_idle("both_idle");

        // byte write to the top lane, then a word write with a late awready
        run_txn(0, 1, 1, 2'd0, 0, 32'h8000_0003, 32'h0000_00AB, 0, 0, 0, 0);
        run_txn(0, 1, 1, 2'd2, 0, 32'h8000_0010, 32'hCAFE_F00D, 0, 3, 0, 1);

        // reset in RD_DATA while the slave has not responded
        @(negedge clk); slave_quiet(); inst_req = 1; inst_addr = 32'h0000_0040; #1;
        chk("rst_grant", inst_addr_ok, 1);
        @(negedge clk); inst_req = 0; arready = 1; #1;
        chk("rst_ar", arvalid, 1);
        @(negedge clk); arready = 0; reset = 1; #1;
        chk("rst_in_rdata", rready, 1);
        @(negedge clk); reset = 0; #1;
        chk_idle("rst_idle");
        data_req = 1; data_wr = 0; #1;
        chk("rst_is_idle", data_addr_ok, 1);
        data_req = 0;

        // AR stall while the fetch address keeps changing
        run_txn(1, 0, 0, 2'd2, 32'h1FC0_0040, 0, 0, 32'h0BAD_F00D, 5, 2, 0);

        for (int t = 0; t < 40; t++) begin
            bit ir, dr, wr;
            logic [1:0] sz;
            logic [31:0] da;
            ir = 1'($urandom); dr = 1'($urandom); wr = 1'($urandom);
            if (!ir && !dr) dr = 1;
            sz = 2'($urandom_range(0, 2));
            da = $urandom;
            da = da & ~((32'd1 << sz) - 32'd1);
            run_txn(ir, dr, wr, sz, $urandom, da, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
